// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for instr_queue.
// The master modport is the environment (fetch + decode + branch unit).
// The slave modport is the queue itself.
interface instr_queue_if #(
  parameter int N     = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [N-1:0]  in_instr;
  logic [N-1:0]  in_pc_next;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  out_instr;
  logic [N-1:0]  out_pc_next;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;
  logic          halted;

  modport master (
    output in_valid, in_instr, in_pc_next, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc_next, count, halted
  );

  modport slave (
    input  in_valid, in_instr, in_pc_next, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc_next, count, halted
  );
endinterface

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: in-order {instr, pc_next} FIFO with
// valid/ready on both sides, branch flush, and HALT-triggered intake stop.
// Optional feature macro: IQ_BYPASS_EN (zero-latency pass-through when empty).
module instr_queue #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  instr_queue_if.slave q_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [N-1:0] NOP = N'(16'h0800);

  logic [N-1:0]  r_mem_instr [DEPTH];
  logic [N-1:0]  r_mem_pc    [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_halted;

  logic          w_full;
  logic          w_empty;
  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_out_valid;
  logic          w_is_halt;

  // Handshake qualification, bypass detection and storage enables
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    w_in_ready  = rst & ~w_full & ~r_halted;
    w_push      = q_if.in_valid & w_in_ready;
    w_is_halt   = (q_if.in_instr[N-1 -: 5] == 5'b00000);
`ifdef IQ_BYPASS_EN
    w_bypass    = w_empty & w_push & ~q_if.flush;
`else
    w_bypass    = 1'b0;
`endif
    w_out_valid = ~w_empty | w_bypass;
    w_pop       = w_out_valid & q_if.out_ready;
    // A bypassed entry consumed in the same cycle never touches storage;
    // a bypassed entry not consumed is written like any other push.
    w_wr_en     = w_push & ~(w_bypass & q_if.out_ready);
    w_rd_en     = w_pop & ~w_bypass;
  end

  // Output drive: idle values whenever nothing is valid
  always_comb begin
    q_if.in_ready    = w_in_ready;
    q_if.out_valid   = w_out_valid;
    q_if.count       = r_count;
    q_if.halted      = r_halted;
    q_if.out_instr   = NOP;
    q_if.out_pc_next = '0;
    if (w_bypass) begin
      q_if.out_instr   = q_if.in_instr;
      q_if.out_pc_next = q_if.in_pc_next;
    end else if (!w_empty) begin
      q_if.out_instr   = r_mem_instr[r_rd_ptr];
      q_if.out_pc_next = r_mem_pc[r_rd_ptr];
    end
  end

  // Pointer, occupancy and halt state; flush outranks push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else if (q_if.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_is_halt) r_halted <= 1'b1;
    end
  end

  // Entry storage (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (w_wr_en && !q_if.flush) begin
      r_mem_instr[r_wr_ptr] <= q_if.in_instr;
      r_mem_pc[r_wr_ptr]    <= q_if.in_pc_next;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue (DEPTH=4, N=16). Build with +define+IQ_BYPASS_EN
// to exercise the zero-latency bypass path instead of the registered path.
module tb_instr_queue;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  instr_queue_if #(.N(16), .DEPTH(4)) iq ();

  instr_queue #(.N(16), .DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (iq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc);
    iq.in_valid   = 1'b1;
    iq.in_instr   = instr;
    iq.in_pc_next = pc;
    tick();
    iq.in_valid   = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp_instr);
    iq.out_ready = 1'b1;
    #1;
    chk(tag, {16'h0, iq.out_instr}, {16'h0, exp_instr});
    tick();
    iq.out_ready = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    iq.in_valid   = 1'b0;
    iq.in_instr   = '0;
    iq.in_pc_next = '0;
    iq.out_ready  = 1'b0;
    iq.flush      = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_count",    {29'h0, iq.count}, 32'd0);
    chk("rst_out_valid",{31'h0, iq.out_valid}, 32'd0);
    chk("rst_in_ready", {31'h0, iq.in_ready}, 32'd0);
    chk("rst_halted",   {31'h0, iq.halted}, 32'd0);
    chk("rst_out_instr",{16'h0, iq.out_instr}, 32'h0800);
    chk("rst_out_pc",   {16'h0, iq.out_pc_next}, 32'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'h0, iq.in_ready}, 32'd1);

    // Three pushes, decode stalled
    push(16'h1111, 16'h0001);
    chk("lat1_out_valid", {31'h0, iq.out_valid}, 32'd1);
    push(16'h2222, 16'h0002);
    push(16'h3333, 16'h0003);
    chk("p3_count",    {29'h0, iq.count}, 32'd3);
    chk("p3_out_instr",{16'h0, iq.out_instr}, 32'h1111);
    chk("p3_out_pc",   {16'h0, iq.out_pc_next}, 32'h0001);
    chk("p3_in_ready", {31'h0, iq.in_ready}, 32'd1);

    // Fill, then a dropped fifth push
    push(16'h4444, 16'h0004);
    chk("full_count",    {29'h0, iq.count}, 32'd4);
    chk("full_in_ready", {31'h0, iq.in_ready}, 32'd0);
    push(16'h5555, 16'h0005);
    chk("drop_count", {29'h0, iq.count}, 32'd4);

    // Drain in order
    pop_chk("drain0", 16'h1111);
    pop_chk("drain1", 16'h2222);
    pop_chk("drain2", 16'h3333);
    pop_chk("drain3", 16'h4444);
    chk("empty_count",    {29'h0, iq.count}, 32'd0);
    chk("empty_out_valid",{31'h0, iq.out_valid}, 32'd0);
    chk("empty_out_instr",{16'h0, iq.out_instr}, 32'h0800);
    chk("empty_in_ready", {31'h0, iq.in_ready}, 32'd1);

    // Steady-state push+pop at count=2, pointers wrap
    push(16'h7000, 16'h7001);
    push(16'h7001, 16'h7002);
    iq.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iq.in_valid   = 1'b1;
      iq.in_instr   = 16'h7002 + 16'(i);
      iq.in_pc_next = 16'h7003 + 16'(i);
      #1;
      chk($sformatf("stream_head%0d", i), {16'h0, iq.out_instr}, 32'h7000 + 32'(i));
      tick();
      chk($sformatf("stream_count%0d", i), {29'h0, iq.count}, 32'd2);
    end
    iq.in_valid  = 1'b0;
    iq.out_ready = 1'b0;
    pop_chk("stream_tail0", 16'h700A);
    chk("stream_tail_pc", {16'h0, iq.out_pc_next}, 32'h700C);
    pop_chk("stream_tail1", 16'h700B);

    // Flush with a concurrent push
    push(16'h8000, 16'h0000);
    push(16'h8001, 16'h0000);
    push(16'h8002, 16'h0000);
    iq.flush      = 1'b1;
    iq.in_valid   = 1'b1;
    iq.in_instr   = 16'h9999;
    iq.in_pc_next = 16'h9999;
    tick();
    iq.flush    = 1'b0;
    iq.in_valid = 1'b0;
    chk("flush_count",    {29'h0, iq.count}, 32'd0);
    chk("flush_out_valid",{31'h0, iq.out_valid}, 32'd0);
    push(16'hA000, 16'hA001);
    chk("flush_after_cnt", {29'h0, iq.count}, 32'd1);
    pop_chk("flush_after_head", 16'hA000);

    // HALT stops intake; queue drains; flush clears
    push(16'h1234, 16'h0010);
    push(16'h0000, 16'h0055);
    chk("halt_halted",   {31'h0, iq.halted}, 32'd1);
    chk("halt_in_ready", {31'h0, iq.in_ready}, 32'd0);
    push(16'h4321, 16'h0011);
    chk("halt_drop_cnt", {29'h0, iq.count}, 32'd2);
    pop_chk("halt_drain0", 16'h1234);
    pop_chk("halt_drain1", 16'h0000);
    chk("halt_drained_cnt", {29'h0, iq.count}, 32'd0);
    chk("halt_drained_rdy", {31'h0, iq.in_ready}, 32'd0);
    iq.flush = 1'b1;
    tick();
    iq.flush = 1'b0;
    chk("halt_flush_halted", {31'h0, iq.halted}, 32'd0);
    chk("halt_flush_rdy",    {31'h0, iq.in_ready}, 32'd1);

    // Empty queue, push with decode ready
    iq.in_valid   = 1'b1;
    iq.in_instr   = 16'hA5A5;
    iq.in_pc_next = 16'h0020;
    iq.out_ready  = 1'b1;
    #1;
`ifdef IQ_BYPASS_EN
    chk("byp_out_valid", {31'h0, iq.out_valid}, 32'd1);
    chk("byp_out_instr", {16'h0, iq.out_instr}, 32'hA5A5);
    chk("byp_out_pc",    {16'h0, iq.out_pc_next}, 32'h0020);
    tick();
    iq.in_valid  = 1'b0;
    iq.out_ready = 1'b0;
    chk("byp_count", {29'h0, iq.count}, 32'd0);
`else
    chk("nobyp_out_valid", {31'h0, iq.out_valid}, 32'd0);
    chk("nobyp_out_instr", {16'h0, iq.out_instr}, 32'h0800);
    tick();
    iq.in_valid  = 1'b0;
    iq.out_ready = 1'b0;
    chk("nobyp_count", {29'h0, iq.count}, 32'd1);
    pop_chk("nobyp_head", 16'hA5A5);
`endif

    // Asynchronous reset mid-fill
    push(16'hB000, 16'h0001);
    push(16'hB001, 16'h0002);
    chk("prerst_count", {29'h0, iq.count}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count",    {29'h0, iq.count}, 32'd0);
    chk("async_rst_out_valid",{31'h0, iq.out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'h0, iq.in_ready}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rerst_in_ready", {31'h0, iq.in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
